// File: rtl/line_buffer3_if.sv
// Pixel-stream and column-output bundle between the upstream pixel source,
// the three-row line buffer and the 3x3 convolver.
interface line_buffer3_if #(
  parameter int BIT_DEPTH = 8
);
  logic [BIT_DEPTH-1:0] pix_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 shift_buffer;
  logic [BIT_DEPTH-1:0] in_l1;
  logic [BIT_DEPTH-1:0] in_l2;
  logic [BIT_DEPTH-1:0] in_l3;
  logic                 col_valid;
  logic                 row_done;
  logic                 frame_done;

  // Side that supplies pixels and consumes columns.
  modport master (
    output pix_in, pix_valid, shift_buffer,
    input  pix_ready, in_l1, in_l2, in_l3, col_valid, row_done, frame_done
  );

  // The line buffer itself.
  modport slave (
    input  pix_in, pix_valid, shift_buffer,
    output pix_ready, in_l1, in_l2, in_l3, col_valid, row_done, frame_done
  );
endinterface

// File: rtl/line_buffer3.sv
// Three-row line buffer: stores raster pixels in a four-bank row ring so one
// row can fill while three complete rows are presented column by column.
module line_buffer3 #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input logic clk,
  input logic rst_n,
  line_buffer3_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 3);

  logic [BIT_DEPTH-1:0] mem [4][IMG_WIDTH];
  logic [1:0]           wr_bank;
  logic [1:0]           rd_bank;
  logic [1:0]           rd_bank1;
  logic [1:0]           rd_bank2;
  logic [CW-1:0]        wr_col;
  logic [CW-1:0]        rd_col;
  logic [2:0]           rows_full;
  logic [2:0]           rows_released;
  logic [RW-1:0]        out_row;
  logic                 accept;
  logic                 row_complete;
  logic                 consume;
  logic                 col_last;
  logic                 frame_last;
  logic                 row_done_q;
  logic                 frame_done_q;

  // A fourth bank lets a new row fill while three rows are being read.
  assign bus.pix_ready = (rows_full < 3'd4);
  assign bus.col_valid = (rows_full >= 3'd3);

  assign accept       = bus.pix_valid && bus.pix_ready;
  assign row_complete = accept && (wr_col == LAST_COL);
  assign consume      = bus.shift_buffer && bus.col_valid;
  assign col_last     = consume && (rd_col == LAST_COL);
  assign frame_last   = col_last && (out_row == LAST_ROW);

  // Bank indices wrap naturally in two bits.
  assign rd_bank1 = rd_bank + 2'd1;
  assign rd_bank2 = rd_bank + 2'd2;

  assign bus.in_l1      = mem[rd_bank][rd_col];
  assign bus.in_l2      = mem[rd_bank1][rd_col];
  assign bus.in_l3      = mem[rd_bank2][rd_col];
  assign bus.row_done   = row_done_q;
  assign bus.frame_done = frame_done_q;

  // Rows given back to the writer: one per output row, all three at frame end.
  always_comb begin
    rows_released = 3'd0;
    if (frame_last) begin
      rows_released = 3'd3;
    end else if (col_last) begin
      rows_released = 3'd1;
    end
  end

  // Pixel storage, cleared on reset so the outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < IMG_WIDTH; c++) begin
          mem[b][c] <= '0;
        end
      end
    end else if (accept) begin
      mem[wr_bank][wr_col] <= bus.pix_in;
    end
  end

  // Write pointer walks the row, then moves on to the next bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col  <= '0;
      wr_bank <= 2'd0;
    end else if (row_complete) begin
      wr_col  <= '0;
      wr_bank <= wr_bank + 2'd1;
    end else if (accept) begin
      wr_col <= wr_col + 1'b1;
    end
  end

  // Read pointer steps per consumed column; at frame end it skips past all three rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_col  <= '0;
      rd_bank <= 2'd0;
      out_row <= '0;
    end else if (frame_last) begin
      rd_col  <= '0;
      rd_bank <= rd_bank + 2'd3;
      out_row <= '0;
    end else if (col_last) begin
      rd_col  <= '0;
      rd_bank <= rd_bank + 2'd1;
      out_row <= out_row + 1'b1;
    end else if (consume) begin
      rd_col <= rd_col + 1'b1;
    end
  end

  // Occupancy: completed rows in, released rows out, both possibly in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_full <= 3'd0;
    end else begin
      rows_full <= rows_full + {2'b00, row_complete} - rows_released;
    end
  end

  // Registered one-cycle pulses following the consuming edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_done_q   <= col_last;
      frame_done_q <= frame_last;
    end
  end
endmodule

// File: tb/tb_line_buffer3.sv
// Directed bench for line_buffer3 with a 4x4 image, pixel k carrying value k.
module tb_line_buffer3;
  localparam int BD = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  line_buffer3_if #(.BIT_DEPTH(BD)) bus ();

  line_buffer3 #(
    .BIT_DEPTH (BD),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  task automatic check_column(input string tag, input int a, input int b, input int c);
    check_output({tag, "_l1"}, 32'(bus.in_l1), a);
    check_output({tag, "_l2"}, 32'(bus.in_l2), b);
    check_output({tag, "_l3"}, 32'(bus.in_l3), c);
  endtask

  // Advance one full cycle, landing on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic valid, input int pixel, input logic shift);
    bus.pix_valid    = valid;
    bus.pix_in       = BD'(pixel);
    bus.shift_buffer = shift;
    tick();
  endtask

  task automatic idle();
    bus.pix_valid    = 1'b0;
    bus.pix_in       = '0;
    bus.shift_buffer = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset mid-stream: partial data must vanish.
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 100 + i, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_ready", 32'(bus.pix_ready), 1);
    check_output("async_rst_colv", 32'(bus.col_valid), 0);
    check_output("async_rst_l1", 32'(bus.in_l1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_output("rst_ready", 32'(bus.pix_ready), 1);
    check_output("rst_colv", 32'(bus.col_valid), 0);
    check_column("rst_col", 0, 0, 0);
    check_output("rst_row_done", 32'(bus.row_done), 0);
    check_output("rst_frame_done", 32'(bus.frame_done), 0);

    // Fill three rows; column appears right after pixel 11.
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1'b1, k, 1'b0);
      check_output($sformatf("fill_colv_%0d", k), 32'(bus.col_valid), (k == 11) ? 1 : 0);
      check_output($sformatf("fill_pulse_%0d", k), 32'({bus.row_done, bus.frame_done}), 0);
    end
    idle();
    check_column("fill_col", 0, 4, 8);
    check_output("fill_ready", 32'(bus.pix_ready), 1);

    // First output row, one column per cycle.
    for (int c = 0; c < 4; c++) begin
      check_column($sformatf("row0_c%0d", c), c, 4 + c, 8 + c);
      check_output($sformatf("row0_colv_%0d", c), 32'(bus.col_valid), 1);
      if (c > 0) check_output($sformatf("row0_rd_%0d", c), 32'(bus.row_done), 0);
      apply_stimulus(1'b0, 0, 1'b1);
    end
    idle();
    check_output("row0_done", 32'(bus.row_done), 1);
    check_output("row0_frame", 32'(bus.frame_done), 0);
    check_output("row0_colv_after", 32'(bus.col_valid), 0);
    // Shift while nothing valid must be ignored.
    apply_stimulus(1'b0, 0, 1'b1);
    idle();
    check_output("row0_done_clear", 32'(bus.row_done), 0);
    for (int k = 12; k < 16; k++) begin
      apply_stimulus(1'b1, k, 1'b0);
      check_output($sformatf("row3_colv_%0d", k), 32'(bus.col_valid), (k == 15) ? 1 : 0);
    end
    idle();
    check_column("row1_first", 4, 8, 12);

    // Second (last) output row ends the frame.
    for (int c = 0; c < 4; c++) begin
      check_column($sformatf("row1_c%0d", c), 4 + c, 8 + c, 12 + c);
      apply_stimulus(1'b0, 0, 1'b1);
    end
    idle();
    check_output("frame_row_done", 32'(bus.row_done), 1);
    check_output("frame_done", 32'(bus.frame_done), 1);
    check_output("frame_rows_full", 32'(dut.rows_full), 0);
    check_output("frame_colv", 32'(bus.col_valid), 0);
    check_output("frame_ready", 32'(bus.pix_ready), 1);
    tick();
    check_output("frame_pulse_clear", 32'({bus.row_done, bus.frame_done}), 0);

    // Backpressure: four rows fill the ring, pixel 16 must wait.
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(1'b1, k, 1'b0);
      check_output($sformatf("bp_ready_%0d", k), 32'(bus.pix_ready), (k == 15) ? 0 : 1);
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 16, 1'b0);
      check_output($sformatf("bp_hold_%0d", i), 32'(bus.pix_ready), 0);
    end
    check_column("bp_col", 0, 4, 8);
    for (int c = 0; c < 4; c++) begin
      check_column($sformatf("bp_c%0d", c), c, 4 + c, 8 + c);
      check_output($sformatf("bp_stall_%0d", c), 32'(bus.pix_ready), 0);
      apply_stimulus(1'b1, 16, 1'b1);
    end
    check_output("bp_release_ready", 32'(bus.pix_ready), 1);
    check_output("bp_release_done", 32'(bus.row_done), 1);
    check_output("bp_release_frame", 32'(bus.frame_done), 0);
    apply_stimulus(1'b1, 16, 1'b0);
    idle();
    check_output("bp_land_bank0", 32'(dut.mem[0][0]), 16);
    check_output("bp_rows_full", 32'(dut.rows_full), 3);
    check_column("bp_next_col", 4, 8, 12);

    // Finish that frame; pixel 16 then begins the next one.
    for (int c = 0; c < 4; c++) apply_stimulus(1'b0, 0, 1'b1);
    idle();
    check_output("f2_frame_done", 32'(bus.frame_done), 1);
    check_output("f2_colv", 32'(bus.col_valid), 0);
    for (int k = 17; k < 31; k++) apply_stimulus(1'b1, k, 1'b0);
    idle();
    check_output("f2_colv_full", 32'(bus.col_valid), 1);
    for (int c = 0; c < 3; c++) begin
      check_column($sformatf("f2_c%0d", c), 16 + c, 20 + c, 24 + c);
      apply_stimulus(1'b0, 0, 1'b1);
    end

    // Row write completes on the same edge as a one-row release.
    check_column("sim_last_col", 19, 23, 27);
    check_output("sim_pre_rows", 32'(dut.rows_full), 3);
    apply_stimulus(1'b1, 31, 1'b1);
    idle();
    check_output("sim_rows_full", 32'(dut.rows_full), 3);
    check_output("sim_colv", 32'(bus.col_valid), 1);
    check_output("sim_ready", 32'(bus.pix_ready), 1);
    check_output("sim_row_done", 32'(bus.row_done), 1);
    check_output("sim_frame_done", 32'(bus.frame_done), 0);
    check_column("sim_next_col", 20, 24, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
